// File: rtl/framebuffer_scanout_if.sv
// rtl/framebuffer_scanout_if.sv - framebuffer port B read bus plus the video pixel stream
interface framebuffer_scanout_if #(
    parameter int PIXEL_WIDTH = 9,
    parameter int ADDR_WIDTH  = 11
);
    logic [ADDR_WIDTH-1:0]  fbAddress;
    logic [PIXEL_WIDTH-1:0] fbData;
    logic [PIXEL_WIDTH-1:0] pixel;
    logic                   hSync;
    logic                   vSync;
    logic                   dataEnable;
    logic                   frameStart;

    modport master (
        output fbAddress,
        input  fbData,
        output pixel,
        output hSync,
        output vSync,
        output dataEnable,
        output frameStart
    );

    modport slave (
        input  fbAddress,
        output fbData,
        input  pixel,
        input  hSync,
        input  vSync,
        input  dataEnable,
        input  frameStart
    );
endinterface

// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - raster timing plus SCALExSCALE upscaled framebuffer readout
// Optional SCANOUT_FRAME_COUNTER_EN adds frameCount and vBlank outputs.
module framebuffer_scanout #(
    parameter int PIXEL_WIDTH = 9,
    parameter int FB_W        = 40,
    parameter int FB_H        = 30,
    parameter int SCALE       = 16,
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic resetN,
    input  logic enable,
    framebuffer_scanout_if.master video
`ifdef SCANOUT_FRAME_COUNTER_EN
    ,
    output logic [15:0] frameCount,
    output logic        vBlank
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int AW = $clog2(FB_W * FB_H);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_HS0   = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_HS1   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ALAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_VS0   = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_VS1   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(SCALE - 1);
    localparam logic [AW-1:0] FB_W_C  = AW'(FB_W);
    localparam logic [AW-1:0] X_LAST  = AW'(FB_W - 1);

    if (H_ACTIVE != FB_W * SCALE) begin : g_hCheck
        $error("framebuffer_scanout: H_ACTIVE must equal FB_W*SCALE");
    end
    if (V_ACTIVE != FB_H * SCALE) begin : g_vCheck
        $error("framebuffer_scanout: V_ACTIVE must equal FB_H*SCALE");
    end

    logic [HW-1:0] hCount;
    logic [VW-1:0] vCount;
    logic [SW-1:0] subX, subY;
    logic [AW-1:0] fbX, rowBase;

    logic hWrap, vWrap, active, hs, vs, first;
    always_comb begin
        hWrap  = (hCount == H_LAST);
        vWrap  = (vCount == V_LAST);
        active = (hCount < H_ACT) && (vCount < V_ACT);
        hs     = (hCount >= H_HS0) && (hCount < H_HS1);
        vs     = (vCount >= V_VS0) && (vCount < V_VS1);
        first  = (hCount == '0) && (vCount == '0);
    end

    // fbX and rowBase never step past the last column/row, so the
    // address stays inside the framebuffer even through blanking.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hCount  <= '0;
            vCount  <= '0;
            subX    <= '0;
            subY    <= '0;
            fbX     <= '0;
            rowBase <= '0;
        end else begin
            hCount <= hWrap ? '0 : hCount + 1'b1;
            if (hWrap) begin
                vCount <= vWrap ? '0 : vCount + 1'b1;
                fbX    <= '0;
                subX   <= '0;
                if (vWrap) begin
                    rowBase <= '0;
                    subY    <= '0;
                end else if (vCount < V_ACT) begin
                    if (subY == S_LAST) begin
                        subY <= '0;
                        if (vCount != V_ALAST) rowBase <= rowBase + FB_W_C;
                    end else begin
                        subY <= subY + 1'b1;
                    end
                end
            end else if (active) begin
                if (subX == S_LAST) begin
                    subX <= '0;
                    if (fbX != X_LAST) fbX <= fbX + 1'b1;
                end else begin
                    subX <= subX + 1'b1;
                end
            end
        end
    end

    assign video.fbAddress = rowBase + fbX;

    // Stage 1 tracks the framebuffer's registered read; stage 2 is the output.
    logic act1, hs1, vs1, fs1;
    logic [PIXEL_WIDTH-1:0] pixelReg;
    logic hSyncReg, vSyncReg, deReg, fsReg;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            act1     <= 1'b0;
            hs1      <= 1'b0;
            vs1      <= 1'b0;
            fs1      <= 1'b0;
            pixelReg <= '0;
            hSyncReg <= ~SYNC_ACTIVE;
            vSyncReg <= ~SYNC_ACTIVE;
            deReg    <= 1'b0;
            fsReg    <= 1'b0;
        end else begin
            act1     <= active;
            hs1      <= hs;
            vs1      <= vs;
            fs1      <= first;
            pixelReg <= (act1 && enable) ? video.fbData : '0;
            hSyncReg <= hs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vSyncReg <= vs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            deReg    <= act1 && enable;
            fsReg    <= fs1;
        end
    end

    assign video.pixel      = pixelReg;
    assign video.hSync      = hSyncReg;
    assign video.vSync      = vSyncReg;
    assign video.dataEnable = deReg;
    assign video.frameStart = fsReg;

`ifdef SCANOUT_FRAME_COUNTER_EN
    logic vb1;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vb1        <= 1'b0;
            vBlank     <= 1'b0;
            frameCount <= '0;
        end else begin
            vb1    <= (vCount >= V_ACT);
            vBlank <= vb1;
            if (fs1) frameCount <= frameCount + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - directed bench for framebuffer_scanout on a 4x2 framebuffer, SCALE 2
module tb_framebuffer_scanout;
    logic clk;
    logic resetN;
    logic enable;
    int   checkCount;
    int   errorCount;

    framebuffer_scanout_if #(.PIXEL_WIDTH(9), .ADDR_WIDTH(3)) video ();

`ifdef SCANOUT_FRAME_COUNTER_EN
    logic [15:0] frameCount;
    logic        vBlank;
`endif

    framebuffer_scanout #(
        .PIXEL_WIDTH(9), .FB_W(4), .FB_H(2), .SCALE(2),
        .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .enable(enable),
        .video(video)
`ifdef SCANOUT_FRAME_COUNTER_EN
        ,
        .frameCount(frameCount),
        .vBlank(vBlank)
`endif
    );

    always #5 clk = ~clk;

    // Framebuffer model: synchronous read, word contents equal their address.
    always @(posedge clk) video.fbData <= 9'(video.fbAddress);

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " pixel"}, 32'(video.pixel), 0);
        check({tag, " dataEnable"}, 32'(video.dataEnable), 0);
        check({tag, " hSync"}, 32'(video.hSync), 1);
        check({tag, " vSync"}, 32'(video.vSync), 1);
        check({tag, " frameStart"}, 32'(video.frameStart), 0);
        check({tag, " fbAddress"}, 32'(video.fbAddress), 0);
    endtask

    // Starts just after reset release; cycle c is the interval after the c-th clock edge.
    task automatic runCycles(input int n, input bit dropEnable);
        bit enHist[1024];
        int p, h, v, ah, av;
        int expPix, expDe, expHs, expVs, expFs, expVb;
        for (int c = 0; c < n; c++) begin
            enable = !(dropEnable && c >= 4 && c <= 6);
            enHist[c] = enable;
            @(negedge clk);
            ah = c % 12;
            av = (c / 12) % 7;
            if (ah < 8 && av < 4)
                check($sformatf("fbAddress c%0d", c), 32'(video.fbAddress), (av / 2) * 4 + ah / 2);
            if (c < 2) begin
                expPix = 0; expDe = 0; expHs = 1; expVs = 1; expFs = 0; expVb = 0;
            end else begin
                p = c - 2;
                h = p % 12;
                v = (p / 12) % 7;
                expDe  = (h < 8 && v < 4 && enHist[c-1]) ? 1 : 0;
                expPix = expDe ? (v / 2) * 4 + h / 2 : 0;
                expHs  = (h == 9 || h == 10) ? 0 : 1;
                expVs  = (v == 5) ? 0 : 1;
                expFs  = (p % 84 == 0) ? 1 : 0;
                expVb  = (v >= 4) ? 1 : 0;
            end
            check($sformatf("pixel c%0d", c), 32'(video.pixel), expPix);
            check($sformatf("dataEnable c%0d", c), 32'(video.dataEnable), expDe);
            check($sformatf("hSync c%0d", c), 32'(video.hSync), expHs);
            check($sformatf("vSync c%0d", c), 32'(video.vSync), expVs);
            check($sformatf("frameStart c%0d", c), 32'(video.frameStart), expFs);
`ifdef SCANOUT_FRAME_COUNTER_EN
            check($sformatf("vBlank c%0d", c), 32'(vBlank), expVb);
`else
            expVb = expVb;
`endif
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        clk = 1'b0;
        resetN = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("in reset");
        @(posedge clk);
        #2;
        resetN = 1'b1;
        runCycles(200, 1'b1);

        // Mid-line 2 of the third frame: output position 198 shows word 7.
        #3;
        check("pre-reset dataEnable", 32'(video.dataEnable), 1);
        check("pre-reset pixel", 32'(video.pixel), 7);
        resetN = 1'b0;
        #1;
        checkResetOutputs("async reset");
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("held reset");
        @(posedge clk);
        #2;
        resetN = 1'b1;
        runCycles(252, 1'b0);
`ifdef SCANOUT_FRAME_COUNTER_EN
        check("frameCount after 3 frames", 32'(frameCount), 3);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
